// File: rtl/hub75_scan_controller.sv
// HUB75 scan controller: fetches one top/bottom pixel line pair per scan row,
// then drives each colour bit-plane out as shift -> latch -> display with
// binary-coded modulation (plane b lit for BASE_ON<<b cycles).
module hub75_scan_controller #(
  parameter int SCAN_RATE = 32,
  parameter int NUM_COLS  = 64,
  parameter int RGB_RES   = 9,
  parameter int BASE_ON   = 4
) (
  input  logic                                  clk_in,
  input  logic                                  rst_n_in,
  input  logic                                  frame_start_in,
  output logic [$clog2(SCAN_RATE)-1:0]          col_idx1_out,
  output logic [$clog2(SCAN_RATE):0]            col_idx2_out,
  input  logic [1:0][NUM_COLS-1:0][RGB_RES-1:0] columns_in,
  output logic [2:0]                            rgb0_out,
  output logic [2:0]                            rgb1_out,
  output logic [$clog2(SCAN_RATE)-1:0]          addr_out,
  output logic                                  hub_clk_out,
  output logic                                  latch_out,
  output logic                                  oe_n_out,
  output logic                                  busy_out,
  output logic                                  frame_done_out
);

  localparam int AW  = $clog2(SCAN_RATE);
  localparam int XW  = $clog2(NUM_COLS);
  localparam int BPC = RGB_RES / 3;
  localparam int PW  = (BPC > 1) ? $clog2(BPC) : 1;
  // Wide enough to hold the longest display period, BASE_ON<<(BPC-1).
  localparam int DW  = $clog2(BASE_ON << (BPC - 1)) + 1;

  localparam logic [AW-1:0] LAST_ROW   = AW'(SCAN_RATE - 1);
  localparam logic [PW-1:0] LAST_PLANE = PW'(BPC - 1);
  localparam logic [XW-1:0] LAST_PIX   = XW'(NUM_COLS - 1);
  localparam logic [DW-1:0] BASE_W     = DW'(BASE_ON);
  localparam logic [AW:0]   SCAN_W     = (AW + 1)'(SCAN_RATE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [AW-1:0] r_row;
  logic [PW-1:0] r_plane;
  logic [XW-1:0] r_pix;
  logic          r_phase;   // 0 = data setup (hub_clk low), 1 = hub_clk high
  logic [DW-1:0] r_disp;
  logic          r_done;

  logic [NUM_COLS-1:0][RGB_RES-1:0] r_top;
  logic [NUM_COLS-1:0][RGB_RES-1:0] r_bot;

  logic               w_shift_last;
  logic [DW-1:0]      w_disp_len;
  logic               w_disp_last;
  logic [RGB_RES-1:0] w_top_sh;
  logic [RGB_RES-1:0] w_bot_sh;
  logic [2:0]         w_rgb0;
  logic [2:0]         w_rgb1;

  assign w_shift_last = r_phase && (r_pix == '0);
  assign w_disp_len   = BASE_W << r_plane;
  assign w_disp_last  = (r_disp == w_disp_len - DW'(1));

  // Shift the current plane down to bit 0 of each channel, then pick R/G/B.
  assign w_top_sh = r_top[r_pix] >> r_plane;
  assign w_bot_sh = r_bot[r_pix] >> r_plane;
  assign w_rgb0   = {w_top_sh[2*BPC], w_top_sh[BPC], w_top_sh[0]};
  assign w_rgb1   = {w_bot_sh[2*BPC], w_bot_sh[BPC], w_bot_sh[0]};

  assign addr_out       = r_row;
  assign busy_out       = (r_state != S_IDLE);
  assign frame_done_out = r_done;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  // Next-state decode and panel/frame-source outputs.
  always_comb begin
    w_state_next = r_state;
    col_idx1_out = '0;
    col_idx2_out = '0;
    rgb0_out     = '0;
    rgb1_out     = '0;
    hub_clk_out  = 1'b0;
    latch_out    = 1'b0;
    oe_n_out     = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (frame_start_in) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        col_idx1_out = r_row;
        col_idx2_out = {1'b0, r_row} + SCAN_W;
        w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        rgb0_out    = w_rgb0;
        rgb1_out    = w_rgb1;
        hub_clk_out = r_phase;
        if (w_shift_last) w_state_next = S_LATCH;
      end
      S_LATCH: begin
        latch_out    = 1'b1;
        w_state_next = S_DISPLAY;
      end
      S_DISPLAY: begin
        oe_n_out = 1'b0;
        if (w_disp_last) begin
          if (r_plane != LAST_PLANE)  w_state_next = S_SHIFT;
          else if (r_row != LAST_ROW) w_state_next = S_FETCH;
          else                        w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Row/plane/pixel/display counters and the end-of-frame pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_row   <= '0;
      r_plane <= '0;
      r_pix   <= '0;
      r_phase <= 1'b0;
      r_disp  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_DISPLAY) && (w_state_next == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (frame_start_in) r_row <= '0;
        end
        S_FETCH: begin
          r_plane <= '0;
          r_pix   <= LAST_PIX;
          r_phase <= 1'b0;
        end
        S_SHIFT: begin
          r_phase <= ~r_phase;
          if (r_phase && (r_pix != '0)) r_pix <= r_pix - XW'(1);
        end
        S_LATCH: begin
          r_disp <= '0;
        end
        S_DISPLAY: begin
          if (w_disp_last) begin
            r_disp <= '0;
            if (r_plane != LAST_PLANE) begin
              r_plane <= r_plane + PW'(1);
              r_pix   <= LAST_PIX;
              r_phase <= 1'b0;
            end else if (r_row != LAST_ROW) begin
              r_row <= r_row + AW'(1);
            end
          end else begin
            r_disp <= r_disp + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Line buffers: captured on the edge leaving FETCH, while the panel is dark.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_top <= '0;
      r_bot <= '0;
    end else if (r_state == S_FETCH) begin
      r_top <= columns_in[0];
      r_bot <= columns_in[1];
    end
  end

endmodule

// File: tb/tb_hub75_scan_controller.sv
// Testbench for hub75_scan_controller: random frame contents served by a
// combinational frame source, checked cycle by cycle against an expected
// output trace built from the row/plane/pixel sequencing rules.
module tb_hub75_scan_controller;

  localparam int SCAN_RATE = 32;
  localparam int NUM_COLS  = 64;
  localparam int RGB_RES   = 9;
  localparam int BASE_ON   = 4;
  localparam int BPC       = RGB_RES / 3;

  logic                     clk_in = 1'b0;
  logic                     rst_n_in = 1'b0;
  logic                     frame_start_in = 1'b0;
  logic [4:0]               col_idx1_out;
  logic [5:0]               col_idx2_out;
  logic [1:0][63:0][8:0]    columns_in;
  logic [2:0]               rgb0_out;
  logic [2:0]               rgb1_out;
  logic [4:0]               addr_out;
  logic                     hub_clk_out;
  logic                     latch_out;
  logic                     oe_n_out;
  logic                     busy_out;
  logic                     frame_done_out;

  // Frame image: 64 pixel lines (0..31 top half, 32..63 bottom half).
  logic [8:0] frame_mem [64][64];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [26:0] e;
    logic [26:0] m;
  } ent_t;
  ent_t trace[$];

  hub75_scan_controller #(
    .SCAN_RATE(SCAN_RATE), .NUM_COLS(NUM_COLS), .RGB_RES(RGB_RES), .BASE_ON(BASE_ON)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_start_in(frame_start_in),
    .col_idx1_out(col_idx1_out), .col_idx2_out(col_idx2_out), .columns_in(columns_in),
    .rgb0_out(rgb0_out), .rgb1_out(rgb1_out), .addr_out(addr_out),
    .hub_clk_out(hub_clk_out), .latch_out(latch_out), .oe_n_out(oe_n_out),
    .busy_out(busy_out), .frame_done_out(frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  // Combinational frame source.
  always_comb begin
    for (int x = 0; x < 64; x++) begin
      columns_in[0][x] = frame_mem[{1'b0, col_idx1_out}][x];
      columns_in[1][x] = frame_mem[col_idx2_out][x];
    end
  end

  function automatic logic [26:0] pk(input logic busy, input logic done, input logic oe_n,
                                     input logic latch, input logic hclk, input logic [4:0] addr,
                                     input logic [4:0] c1, input logic [5:0] c2,
                                     input logic [2:0] r0, input logic [2:0] r1);
    return {busy, done, oe_n, latch, hclk, addr, c1, c2, r0, r1};
  endfunction

  function automatic logic [26:0] obs_now();
    return {busy_out, frame_done_out, oe_n_out, latch_out, hub_clk_out, addr_out,
            col_idx1_out, col_idx2_out, rgb0_out, rgb1_out};
  endfunction

  function automatic logic [2:0] plane_bits(input logic [8:0] pix, input int p);
    logic [8:0] v;
    v = pix >> p;
    return {v[2*BPC], v[BPC], v[0]};
  endfunction

  function automatic void push(input logic [26:0] e, input logic [26:0] m);
    ent_t t;
    t.e = e;
    t.m = m;
    trace.push_back(t);
  endfunction

  // Expected output trace of one scan row: fetch, then per plane
  // 64 pixels x 2 phases, one latch cycle, BASE_ON<<p display cycles.
  function automatic void build_row(input int r);
    logic [4:0]  ra;
    logic [5:0]  rb;
    logic [26:0] m_ctrl, m_fetch, m_shift;
    logic [2:0]  t, b;
    ra      = 5'(r);
    rb      = 6'(r + SCAN_RATE);
    m_ctrl  = pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '1, '0, '0, '0, '0);
    m_fetch = m_ctrl | pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '1, '1, '0, '0);
    m_shift = m_ctrl | pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '1, '1);
    trace.delete();
    push(pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ra, ra, rb, '0, '0), m_fetch);
    for (int p = 0; p < BPC; p++) begin
      for (int x = NUM_COLS - 1; x >= 0; x--) begin
        t = plane_bits(frame_mem[r][x], p);
        b = plane_bits(frame_mem[r + SCAN_RATE][x], p);
        push(pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ra, '0, '0, t, b), m_shift);
        push(pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ra, '0, '0, t, b), m_shift);
      end
      push(pk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ra, '0, '0, '0, '0), m_ctrl);
      for (int d = 0; d < (BASE_ON << p); d++)
        push(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ra, '0, '0, '0, '0), m_ctrl);
    end
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        frame_mem[i][j] = 9'($urandom);
  endtask

  task automatic start_frame();
    frame_start_in = 1'b1;
    @(negedge clk_in);
    frame_start_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
  endtask

  // Walks n_rows rows from the current (FETCH row 0) cycle. For a full frame
  // also checks the done cycle; 'noisy' sprinkles ignored start pulses and
  // 'chain' fires a start pulse coincident with frame_done_out.
  task automatic test_frame(input int n_rows, input bit noisy, input bit chain);
    logic [26:0] obs, e, m;
    for (int r = 0; r < n_rows; r++) begin
      build_row(r);
      for (int i = 0; i < trace.size(); i++) begin
        obs = obs_now();
        e   = trace[i].e;
        m   = trace[i].m;
        vectors++;
        if ((obs & m) !== (e & m)) begin
          miscompares++;
          if (miscompares <= 20)
            $display("FAIL frame row %0d cycle %0d: got %h want %h mask %h", r, i, obs & m, e & m, m);
        end
        frame_start_in = noisy && ($urandom_range(0, 149) == 0);
        @(negedge clk_in);
      end
    end
    frame_start_in = 1'b0;
    if (n_rows == SCAN_RATE) begin
      m = pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, '0, '0, '0, '0);
      e = pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
      obs = obs_now();
      vectors++;
      if ((obs & m) !== e) begin
        miscompares++;
        $display("FAIL frame_done cycle: got %h want %h", obs & m, e);
      end
      frame_start_in = chain;
      @(negedge clk_in);
      frame_start_in = 1'b0;
      if (!chain) begin
        e = pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
        obs = obs_now();
        vectors++;
        if ((obs & m) !== e) begin
          miscompares++;
          $display("FAIL after frame_done: got %h want %h", obs & m, e);
        end
      end
    end
    $display("frame walk: %0d rows noisy=%0d chain=%0d", n_rows, noisy, chain);
  endtask

  task automatic test_reset();
    logic [26:0] rst_v;
    rst_v = pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    rst_n_in = 1'b0;
    frame_start_in = 1'b0;
    repeat (3) @(negedge clk_in);
    vectors++;
    if (obs_now() !== rst_v) begin
      miscompares++;
      $display("FAIL reset outputs: got %h want %h", obs_now(), rst_v);
    end
    rst_n_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      vectors++;
      if (obs_now() !== rst_v) begin
        miscompares++;
        $display("FAIL idle after reset cycle %0d: got %h want %h", i, obs_now(), rst_v);
      end
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_single_frame();
    fill_random();
    start_frame();
    test_frame(SCAN_RATE, 1'b0, 1'b0);
  endtask

  // Row 0 with top x=5 = 101_010_001, bottom line all zero.
  task automatic test_bit_planes();
    logic [2:0] exp_rgb [3];
    int   plane, edges, low;
    logic prev_h, prev_oe;
    exp_rgb[0] = 3'b101;
    exp_rgb[1] = 3'b010;
    exp_rgb[2] = 3'b100;
    fill_random();
    frame_mem[0][5] = 9'b101_010_001;
    for (int x = 0; x < 64; x++) frame_mem[SCAN_RATE][x] = '0;
    start_frame();
    plane = 0; edges = 0; low = 0;
    prev_h = 1'b0; prev_oe = 1'b1;
    for (int c = 0; c < 417; c++) begin
      if (hub_clk_out && !prev_h) begin
        edges++;
        if (edges == 59) begin
          vectors++;
          if (!(plane < 3 && rgb0_out === exp_rgb[plane] && rgb1_out === 3'b000)) begin
            miscompares++;
            $display("FAIL plane %0d pixel 59: rgb0=%b rgb1=%b want %b/000", plane, rgb0_out, rgb1_out,
                     (plane < 3) ? exp_rgb[plane] : 3'b000);
          end
        end
      end
      if (latch_out) begin
        vectors++;
        if (edges !== 64) begin
          miscompares++;
          $display("FAIL hub_clk edges before latch plane %0d: got %0d want 64", plane, edges);
        end
        edges = 0;
      end
      vectors++;
      if (!oe_n_out && (latch_out || hub_clk_out)) begin
        miscompares++;
        $display("FAIL oe_n low with latch=%b hub_clk=%b at cycle %0d", latch_out, hub_clk_out, c);
      end
      if (!oe_n_out) low++;
      if (oe_n_out && !prev_oe) begin
        vectors++;
        if (low !== (BASE_ON << plane)) begin
          miscompares++;
          $display("FAIL display length plane %0d: got %0d want %0d", plane, low, BASE_ON << plane);
        end
        plane++;
        low = 0;
      end
      prev_h  = hub_clk_out;
      prev_oe = oe_n_out;
      @(negedge clk_in);
    end
    vectors++;
    if (plane !== BPC) begin
      miscompares++;
      $display("FAIL planes displayed in row 0: got %0d want %0d", plane, BPC);
    end
    $display("bit planes: row 0 checked");
    do_reset();
  endtask

  task automatic test_back_to_back();
    fill_random();
    start_frame();
    test_frame(SCAN_RATE, 1'b1, 1'b1);
    test_frame(SCAN_RATE, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    logic [26:0] rst_v;
    int k;
    rst_v = pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    fill_random();
    start_frame();
    test_frame(10, 1'b0, 1'b0);
    k = $urandom_range(1, 120);
    repeat (k) @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    vectors++;
    if (obs_now() !== rst_v) begin
      miscompares++;
      $display("FAIL async reset in row 10: got %h want %h", obs_now(), rst_v);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      vectors++;
      if (obs_now() !== rst_v) begin
        miscompares++;
        $display("FAIL held reset cycle %0d: got %h want %h", i, obs_now(), rst_v);
      end
    end
    rst_n_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      vectors++;
      if (obs_now() !== rst_v) begin
        miscompares++;
        $display("FAIL idle after abort cycle %0d: got %h want %h", i, obs_now(), rst_v);
      end
    end
    $display("mid-frame reset after %0d shift cycles", k);
    fill_random();
    start_frame();
    test_frame(1, 1'b0, 1'b0);
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        frame_mem[i][j] = '0;
    test_reset();
    test_single_frame();
    test_bit_planes();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
